// File: rtl/apb_slave.sv
// APB completer over a byte-wide register file. Latency: pready in the 1+WAIT_CYCLES-th access cycle.
// Backpressure via pready wait states; out-of-range offsets answer pslverr and never touch storage.
module apb_slave #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [8:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         MSZ     = 1 << AW;
   localparam logic [8:0] DEPTH_W = 9'(DEPTH);
   localparam logic [3:0] WAIT_W  = 4'(WAIT_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic        write_q, write_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [7:0]  prdata_q, prdata_d;
   logic [7:0]  mem_q [MSZ];

   logic        mem_we;
   logic        setup;
   logic        in_range;
   logic [7:0]  rd_val;
   logic        unused_bits;

   // Storage is rounded up to a power of two; entries at or above DEPTH are never written.
   assign in_range    = ({1'b0, paddr[7:0]} < DEPTH_W);
   assign rd_val      = in_range ? mem_q[paddr[AW-1:0]] : 8'h00;
   assign setup       = psel && !penable;
   assign unused_bits = ^{paddr[8], addr_q};

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      wcnt_d   = wcnt_q;
      prdata_d = prdata_q;
      mem_we   = 1'b0;

      // A setup phase seen in ACCESS restarts the transfer and drops the old one.
      if (setup) begin
         addr_d  = paddr[7:0];
         write_d = pwrite;
         wdata_d = pwdata;
         err_d   = !in_range;
         wcnt_d  = WAIT_W;
         state_d = ACCESS;
         if (!pwrite) begin
            prdata_d = rd_val;
         end
      end else if (state_q == ACCESS) begin
         if (!psel) begin
            state_d = IDLE;
         end else if (wcnt_q != 4'd0) begin
            wcnt_d = wcnt_q - 4'd1;
         end else begin
            mem_we  = write_q && !err_q;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (!preset) begin
         state_q  <= IDLE;
         addr_q   <= 8'h00;
         write_q  <= 1'b0;
         wdata_q  <= 8'h00;
         err_q    <= 1'b0;
         wcnt_q   <= 4'd0;
         prdata_q <= 8'h00;
         for (int i = 0; i < MSZ; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         wcnt_q   <= wcnt_d;
         prdata_q <= prdata_d;
         if (mem_we) begin
            mem_q[addr_q[AW-1:0]] <= wdata_q;
         end
      end
   end

   assign prdata  = prdata_q;
   assign pready  = (state_q == ACCESS) && (wcnt_q == 4'd0);
   assign pslverr = pready && err_q;

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: four builds (WAIT_CYCLES 1, 0, 15, 2) share the bus, each with its own psel.
module tb_apb_slave;

   typedef struct {
      logic [7:0] rd;
      logic       err;
      int         lat;
      bit         chk_rd;
   } exp_t;

   logic       pclk;
   logic       preset;
   logic [3:0] psel_v;
   logic       penable;
   logic       pwrite;
   logic [8:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata_v [4];
   logic [3:0] pready_v;
   logic [3:0] pslverr_v;

   int         waits [4] = '{1, 0, 15, 2};
   logic [7:0] mdl [4][256];
   exp_t       sb [$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   apb_slave #(.DEPTH(64), .WAIT_CYCLES(1)) u_w1 (
      .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));
   apb_slave #(.DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
      .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));
   apb_slave #(.DEPTH(64), .WAIT_CYCLES(15)) u_w15 (
      .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));
   apb_slave #(.DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
      .pclk(pclk), .preset(preset), .psel(psel_v[3]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[3]), .pready(pready_v[3]), .pslverr(pslverr_v[3]));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   task automatic clear_model();
      for (int d = 0; d < 4; d++) begin
         for (int a = 0; a < 256; a++) begin
            mdl[d][a] = 8'h00;
         end
      end
   endtask

   task automatic go_idle();
      @(negedge pclk);
      psel_v  = 4'b0000;
      penable = 1'b0;
   endtask

   // One full transfer on build d; expectation queued at setup, checked when pready appears.
   task automatic xfer(input int d, input bit wr, input logic [8:0] a, input logic [7:0] wd,
                       output int t_start, output int t_done);
      exp_t e;
      exp_t got;
      int   n;
      e.err    = (a[7:0] >= 8'd64);
      e.lat    = 1 + waits[d];
      e.chk_rd = !wr;
      e.rd     = e.err ? 8'h00 : mdl[d][a[7:0]];
      sb.push_back(e);
      @(negedge pclk);
      t_start = cyc;
      psel_v  = 4'b0001 << d;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      @(negedge pclk);
      penable = 1'b1;
      paddr   = ~a;
      pwdata  = ~wd;
      pwrite  = !wr;
      n = 1;
      while (!pready_v[d] && n < 40) begin
         @(negedge pclk);
         n++;
      end
      t_done = cyc;
      got = sb.pop_front();
      checks++;
      if (n !== got.lat) begin
         errors++;
         $display("FAIL latency dut%0d addr=%h: pready in access cycle %0d, required %0d", d, a, n, got.lat);
      end
      checks++;
      if (pslverr_v[d] !== got.err) begin
         errors++;
         $display("FAIL pslverr dut%0d addr=%h: got %b, required %b", d, a, pslverr_v[d], got.err);
      end
      if (got.chk_rd) begin
         checks++;
         if (prdata_v[d] !== got.rd) begin
            errors++;
            $display("FAIL prdata dut%0d addr=%h: got %h, required %h", d, a, prdata_v[d], got.rd);
         end
      end
      if (wr && !got.err && pready_v[d]) mdl[d][a[7:0]] = wd;
   endtask

   task automatic test_reset();
      preset  = 1'b0;
      psel_v  = 4'b0000;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 9'h000;
      pwdata  = 8'h00;
      clear_model();
      repeat (3) @(negedge pclk);
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (pready_v[d] !== 1'b0 || pslverr_v[d] !== 1'b0 || prdata_v[d] !== 8'h00) begin
            errors++;
            $display("FAIL reset_state dut%0d: pready=%b pslverr=%b prdata=%h, required 0 0 00",
                     d, pready_v[d], pslverr_v[d], prdata_v[d]);
         end
      end
      preset  = 1'b1;
      psel_v  = 4'b0001;
      penable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         checks++;
         if (pready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL no_setup_access cycle %0d: pready=%b, required 0", i, pready_v[0]);
         end
      end
      go_idle();
   endtask

   task automatic test_write_read();
      int s, t;
      xfer(0, 1'b1, 9'h010, 8'hA5, s, t);
      go_idle();
      xfer(0, 1'b0, 9'h010, 8'h00, s, t);
      go_idle();
   endtask

   task automatic test_back_to_back();
      int s0, t0, s1, t1;
      xfer(0, 1'b1, 9'h001, 8'h3C, s0, t0);
      xfer(0, 1'b0, 9'h001, 8'h00, s1, t1);
      checks++;
      if (t1 - s0 + 1 !== 6) begin
         errors++;
         $display("FAIL back_to_back_cycles: took %0d cycles, required 6", t1 - s0 + 1);
      end
      go_idle();
   endtask

   task automatic test_out_of_range();
      int s, t;
      xfer(0, 1'b1, 9'h040, 8'hFF, s, t);
      xfer(0, 1'b0, 9'h040, 8'h00, s, t);
      xfer(0, 1'b0, 9'h03F, 8'h00, s, t);
      xfer(0, 1'b1, 9'h105, 8'h66, s, t);
      xfer(0, 1'b0, 9'h005, 8'h00, s, t);
      xfer(0, 1'b0, 9'h1FF, 8'h00, s, t);
      go_idle();
   endtask

   task automatic test_wait_extremes();
      int s, t;
      xfer(1, 1'b1, 9'h020, 8'h11, s, t);
      xfer(1, 1'b0, 9'h020, 8'h00, s, t);
      go_idle();
      xfer(2, 1'b1, 9'h021, 8'h22, s, t);
      xfer(2, 1'b0, 9'h021, 8'h00, s, t);
      go_idle();
   endtask

   task automatic test_abort();
      int s, t;
      @(negedge pclk);
      psel_v  = 4'b1000;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 9'h002;
      pwdata  = 8'h77;
      @(negedge pclk);
      psel_v  = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         checks++;
         if (pready_v[3] !== 1'b0) begin
            errors++;
            $display("FAIL abort_pready cycle %0d: pready=%b, required 0", i, pready_v[3]);
         end
      end
      xfer(3, 1'b0, 9'h002, 8'h00, s, t);
      go_idle();
   endtask

   task automatic test_reset_mid();
      int s, t;
      xfer(3, 1'b1, 9'h004, 8'h5A, s, t);
      xfer(3, 1'b0, 9'h004, 8'h00, s, t);
      @(negedge pclk);
      psel_v  = 4'b1000;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 9'h003;
      pwdata  = 8'h99;
      @(negedge pclk);
      penable = 1'b1;
      preset  = 1'b0;
      @(negedge pclk);
      checks++;
      if (pready_v[3] !== 1'b0 || prdata_v[3] !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: pready=%b prdata=%h, required 0 00", pready_v[3], prdata_v[3]);
      end
      preset  = 1'b1;
      psel_v  = 4'b0000;
      penable = 1'b0;
      clear_model();
      xfer(3, 1'b0, 9'h003, 8'h00, s, t);
      xfer(3, 1'b0, 9'h004, 8'h00, s, t);
      go_idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_out_of_range();
      test_wait_extremes();
      test_abort();
      test_reset_mid();
      repeat (2) @(negedge pclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
